lsu_mmio_param: RTL and testbench

Parametrised load/store unit with a handshaked multi-cycle interface. It decodes a core request into one of three regions: synchronous-read data memory, a bank of N memory-mapped output registers (LEDs/HEX/LCD), or M synchronised input ports (switches/buttons). It performs RISC-V byte/half/word stores with byte-lane merging and sign/zero-extended loads, and flags misaligned, unmapped or illegal accesses. It sits between the core's MEM stage and the board I/O, and it stalls the core with `o_stall` until each access completes.

---
 rtl/lsu_mmio_param.sv | 230 +++++++++++++++++++++++
 tb/tb_lsu_mmio_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mmio_param.sv
// lsu_mmio_param: load/store unit between the core MEM stage and board I/O.
// It decodes a request into one of three regions: a synchronous-read data RAM,
// a bank of N_OUT output registers, or N_IN synchronised input ports.
// It performs RISC-V B/H/W stores with byte-lane merging and sign- or
// zero-extended loads. Misaligned, unmapped and illegal accesses are flagged
// as faults and have no side effects.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_req           access request, held by the core until o_done
//   i_wren          1 = store, 0 = load
//   i_funct3        RISC-V width code (B/H/W/BU/HU)
//   i_addr          byte address; only [15:0] is decoded
//   i_wdata         right-aligned store data
//   i_io_in         asynchronous input ports; port k is [32k+31:32k]
//   o_rdata         extended load result, valid with o_done
//   o_done          one-cycle completion pulse
//   o_err           access fault, valid with o_done
//   o_stall         i_req & ~o_done
//   o_io_out        output register contents; register k is [32k+31:32k]
module lsu_mmio_param #(
   parameter int          DMEM_WORDS  = 2048,
   parameter logic [15:0] DMEM_BASE   = 16'h2000,
   parameter logic [15:0] OUT_BASE    = 16'h7000,
   parameter int          N_OUT       = 8,
   parameter logic [15:0] IN_BASE     = 16'h7800,
   parameter int          N_IN        = 2,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_req,
   input  logic                  i_wren,
   input  logic [2:0]            i_funct3,
   input  logic [31:0]           i_addr,
   input  logic [31:0]           i_wdata,
   input  logic [32*N_IN-1:0]    i_io_in,
   output logic [31:0]           o_rdata,
   output logic                  o_done,
   output logic                  o_err,
   output logic                  o_stall,
   output logic [32*N_OUT-1:0]   o_io_out
);

   localparam int AW = $clog2(DMEM_WORDS);

   // Region bounds are evaluated in 17 bits so that a region ending exactly
   // at 0x10000 does not wrap around.
   localparam logic [16:0] DMEM_LO = {1'b0, DMEM_BASE};
   localparam logic [16:0] DMEM_HI = DMEM_LO + 17'(4*DMEM_WORDS);
   localparam logic [16:0] OUT_LO  = {1'b0, OUT_BASE};
   localparam logic [16:0] OUT_HI  = OUT_LO + 17'(4*N_OUT);
   localparam logic [16:0] IN_LO   = {1'b0, IN_BASE};
   localparam logic [16:0] IN_HI   = IN_LO + 17'(4*N_IN);

   typedef enum logic [1:0] {IDLE, DRD, RESP} state_t;

   state_t state_q, state_d;

   logic [15:0] a;
   logic [16:0] a17;
   logic        in_dmem, in_out, in_in, unmapped, misal, bad_f3, fault;
   logic [AW-1:0] widx;
   logic [3:0]  out_idx;
   logic [2:0]  in_idx;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [31:0] io_word;
   logic        wr_mem, wr_out, accept, cap, cap_err;
   logic [31:0] cap_data;

   logic [31:0] mem [DMEM_WORDS];
   logic [31:0] ram_q;
   logic [N_OUT-1:0][31:0] out_q;
   logic [SYNC_STAGES-1:0][32*N_IN-1:0] sync_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   // The upper address half is architecturally ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^i_addr[31:16];

   // Select the addressed byte/half and extend it; funct3[2] selects zero-extension.
   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  extract = {{24{b[7]}}, b};
         3'b100:  extract = {24'b0, b};
         3'b001:  extract = {{16{h[15]}}, h};
         3'b101:  extract = {16'b0, h};
         default: extract = w;
      endcase
   endfunction

   // ---------------- decode ----------------
   assign a        = i_addr[15:0];
   assign a17      = {1'b0, a};
   assign in_dmem  = (a17 >= DMEM_LO) && (a17 < DMEM_HI);
   assign in_out   = (a17 >= OUT_LO)  && (a17 < OUT_HI);
   assign in_in    = (a17 >= IN_LO)   && (a17 < IN_HI);
   assign unmapped = ~(in_dmem | in_out | in_in);
   assign widx     = AW'((a - DMEM_BASE) >> 2);
   assign out_idx  = 4'((a - OUT_BASE) >> 2);
   assign in_idx   = 3'((a - IN_BASE) >> 2);

   assign misal  = ((i_funct3[1:0] == 2'b01) && a[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (a[1:0] != 2'b00));
   assign bad_f3 = (i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11);
   assign fault  = misal | bad_f3 | unmapped | (i_wren & (in_in | i_funct3[2]));

   // Sub-word store data is replicated so every enabled lane sees the right byte.
   always_comb begin
      be = 4'b1111;
      wd = i_wdata;
      case (i_funct3[1:0])
         2'b00: begin be = 4'b0001 << a[1:0]; wd = {4{i_wdata[7:0]}};  end
         2'b01: begin be = 4'b0011 << a[1:0]; wd = {2{i_wdata[15:0]}}; end
         default: ;
      endcase
   end

   // Readback mux for the output bank and the synchronised inputs.
   always_comb begin
      io_word = '0;
      for (int k = 0; k < N_OUT; k++)
         if (in_out && out_idx == 4'(k)) io_word = out_q[k];
      for (int k = 0; k < N_IN; k++)
         if (in_in && in_idx == 3'(k)) io_word = sync_q[SYNC_STAGES-1][32*k +: 32];
   end

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      wr_mem   = 1'b0;
      wr_out   = 1'b0;
      cap      = 1'b0;
      cap_err  = 1'b0;
      cap_data = '0;
      case (state_q)
         IDLE: if (i_req) begin
            accept = 1'b1;
            if (fault) begin
               cap     = 1'b1;
               cap_err = 1'b1;
               state_d = RESP;
            end else if (i_wren) begin
               wr_mem  = in_dmem & ~i_rst;
               wr_out  = in_out;
               cap     = 1'b1;
               state_d = RESP;
            end else if (in_dmem) begin
               state_d = DRD;
            end else begin
               cap      = 1'b1;
               cap_data = extract(io_word, i_funct3, a[1:0]);
               state_d  = RESP;
            end
         end
         DRD: begin
            cap      = 1'b1;
            cap_data = extract(ram_q, f3_q, off_q);
            state_d  = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   // The RAM reads every cycle; during DRD ram_q holds the word addressed at acceptance.
   always_ff @(posedge i_clk) begin
      if (wr_mem)
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
      ram_q <= mem[widx];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         out_q <= '0;
      end else if (wr_out) begin
         for (int k = 0; k < N_OUT; k++)
            for (int b = 0; b < 4; b++)
               if (out_idx == 4'(k) && be[b]) out_q[k][8*b +: 8] <= wd[8*b +: 8];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], i_io_in};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
      end else begin
         if (cap) begin
            rdata_q <= cap_data;
            err_q   <= cap_err;
         end
         if (accept) begin
            f3_q  <= i_funct3;
            off_q <= a[1:0];
         end
      end
   end

   assign o_done   = (state_q == RESP);
   assign o_rdata  = rdata_q;
   assign o_err    = err_q;
   assign o_stall  = i_req & ~o_done;
   assign o_io_out = out_q;

endmodule

// File: tb/tb_lsu_mmio_param.sv
// Self-checking bench for lsu_mmio_param: directed table, multi-cycle corner
// sequences (input synchroniser, reset mid-load) and randomised accesses
// checked against a byte-addressed reference model.
module tb_lsu_mmio_param;

   localparam int          DMEM_WORDS  = 2048;
   localparam logic [15:0] DMEM_BASE   = 16'h2000;
   localparam logic [15:0] OUT_BASE    = 16'h7000;
   localparam int          N_OUT       = 8;
   localparam logic [15:0] IN_BASE     = 16'h7800;
   localparam int          N_IN        = 2;
   localparam int          SYNC_STAGES = 2;

   logic                i_clk = 1'b0;
   logic                i_rst = 1'b1;
   logic                i_req = 1'b0;
   logic                i_wren = 1'b0;
   logic [2:0]          i_funct3 = 3'b0;
   logic [31:0]         i_addr = '0;
   logic [31:0]         i_wdata = '0;
   logic [32*N_IN-1:0]  i_io_in = '0;
   logic [31:0]         o_rdata;
   logic                o_done, o_err, o_stall;
   logic [32*N_OUT-1:0] o_io_out;

   lsu_mmio_param #(
      .DMEM_WORDS(DMEM_WORDS), .DMEM_BASE(DMEM_BASE), .OUT_BASE(OUT_BASE),
      .N_OUT(N_OUT), .IN_BASE(IN_BASE), .N_IN(N_IN), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_wren(i_wren),
      .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .i_io_in(i_io_in),
      .o_rdata(o_rdata), .o_done(o_done), .o_err(o_err), .o_stall(o_stall),
      .o_io_out(o_io_out)
   );

   always #5 i_clk = ~i_clk;

   int n_chk = 0;
   int n_err = 0;
   logic [32*N_OUT-1:0] io_at_done;

   // Reference model: a flat byte store covering DMEM and the output bank.
   logic [7:0] bmem [int];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] get_b(input int ad);
      return bmem.exists(ad) ? bmem[ad] : 8'h00;
   endfunction

   task automatic model_reset_out();
      for (int i = 0; i < 4*N_OUT; i++) bmem[int'(OUT_BASE) + i] = 8'h00;
   endtask

   task automatic model_acc(input logic wren, input logic [2:0] f3, input logic [15:0] a,
                            input logic [31:0] wdv, output logic [31:0] rd,
                            output logic err, output int lat);
      int ai, r, size;
      logic [31:0] v;
      ai   = int'(a);
      r    = 0;
      if (ai >= int'(DMEM_BASE) && ai < int'(DMEM_BASE) + 4*DMEM_WORDS) r = 1;
      if (ai >= int'(OUT_BASE)  && ai < int'(OUT_BASE) + 4*N_OUT)       r = 2;
      if (ai >= int'(IN_BASE)   && ai < int'(IN_BASE) + 4*N_IN)         r = 3;
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      err  = (r == 0) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
             (wren && (f3[2] || r == 3)) || ((ai % size) != 0);
      v = '0;
      if (!err && wren) begin
         for (int j = 0; j < size; j++) bmem[ai + j] = wdv[8*j +: 8];
      end else if (!err) begin
         for (int j = 0; j < size; j++) begin
            if (r == 3) v[8*j +: 8] = i_io_in[(ai - int'(IN_BASE) + j)*8 +: 8];
            else        v[8*j +: 8] = get_b(ai + j);
         end
         if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
         if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      end
      rd  = err ? 32'h0 : v;
      lat = (err || wren || r != 1) ? 1 : 2;
   endtask

   task automatic chk_io();
      logic [31:0] e;
      for (int k = 0; k < N_OUT; k++) begin
         for (int j = 0; j < 4; j++) e[8*j +: 8] = get_b(int'(OUT_BASE) + 4*k + j);
         chk($sformatf("io_out[%0d]", k), io_at_done[32*k +: 32], e);
      end
   endtask

   // One handshaked access; lat counts edges from acceptance to the o_done cycle.
   task automatic access(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdv, output logic [31:0] rd,
                         output logic err, output int lat);
      bit got;
      @(negedge i_clk);
      i_req = 1'b1; i_wren = wren; i_funct3 = f3; i_addr = addr; i_wdata = wdv;
      #1;
      chk("stall_pre", {31'b0, o_stall}, 32'd1);
      lat = 99; rd = '0; err = 1'b0; got = 0;
      for (int c = 1; c <= 8; c++) begin
         if (!got) begin
            @(posedge i_clk); #1;
            if (o_done) begin
               got = 1; lat = c; rd = o_rdata; err = o_err; io_at_done = o_io_out;
               chk("stall_done", {31'b0, o_stall}, 32'd0);
            end
         end
      end
      i_req = 1'b0;
      @(posedge i_clk);
   endtask

   typedef struct {
      logic        wren;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t tbl[19];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lt, mlt;
      logic [15:0] a;
      logic [2:0]  f3;
      logic        w;
      logic [31:0] wv;
      logic [15:0] unm [6];

      tbl[0]  = '{1'b1, 3'b010, 32'h2004, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1};
      tbl[1]  = '{1'b0, 3'b010, 32'h2004, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 2};
      tbl[2]  = '{1'b1, 3'b010, 32'h2008, 32'h11223344, 1'b0, 32'h0,        1'b0, 1};
      tbl[3]  = '{1'b1, 3'b000, 32'h2009, 32'h000000AA, 1'b0, 32'h0,        1'b0, 1};
      tbl[4]  = '{1'b0, 3'b010, 32'h2008, 32'h0,        1'b1, 32'h1122AA44, 1'b0, 2};
      tbl[5]  = '{1'b0, 3'b000, 32'h2009, 32'h0,        1'b1, 32'hFFFFFFAA, 1'b0, 2};
      tbl[6]  = '{1'b0, 3'b100, 32'h2009, 32'h0,        1'b1, 32'h000000AA, 1'b0, 2};
      tbl[7]  = '{1'b1, 3'b001, 32'h200A, 32'h00008001, 1'b0, 32'h0,        1'b0, 1};
      tbl[8]  = '{1'b0, 3'b010, 32'h2008, 32'h0,        1'b1, 32'h8001AA44, 1'b0, 2};
      tbl[9]  = '{1'b0, 3'b001, 32'h200A, 32'h0,        1'b1, 32'hFFFF8001, 1'b0, 2};
      tbl[10] = '{1'b1, 3'b010, 32'h7004, 32'h12345678, 1'b0, 32'h0,        1'b0, 1};
      tbl[11] = '{1'b1, 3'b000, 32'h7007, 32'h00000000, 1'b0, 32'h0,        1'b0, 1};
      tbl[12] = '{1'b0, 3'b010, 32'h7004, 32'h0,        1'b1, 32'h00345678, 1'b0, 1};
      tbl[13] = '{1'b0, 3'b010, 32'h2002, 32'h0,        1'b1, 32'h0,        1'b1, 1};
      tbl[14] = '{1'b1, 3'b001, 32'h7001, 32'h0000FFFF, 1'b1, 32'h0,        1'b1, 1};
      tbl[15] = '{1'b1, 3'b010, 32'h7800, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 1};
      tbl[16] = '{1'b0, 3'b010, 32'h5000, 32'h0,        1'b1, 32'h0,        1'b1, 1};
      tbl[17] = '{1'b0, 3'b011, 32'h2000, 32'h0,        1'b1, 32'h0,        1'b1, 1};
      tbl[18] = '{1'b0, 3'b101, 32'h200A, 32'h0,        1'b1, 32'h00008001, 1'b0, 2};

      // Reset state
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      model_reset_out();
      chk("rst_done",  {31'b0, o_done},  32'd0);
      chk("rst_err",   {31'b0, o_err},   32'd0);
      chk("rst_rdata", o_rdata,          32'd0);
      chk("rst_stall", {31'b0, o_stall}, 32'd0);
      io_at_done = o_io_out;
      chk_io();

      // Directed table
      for (int i = 0; i < 19; i++) begin
         model_acc(tbl[i].wren, tbl[i].f3, tbl[i].addr[15:0], tbl[i].wdata, mrd, mer, mlt);
         access(tbl[i].wren, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lt);
         chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
         chk($sformatf("tbl%0d_lat", i), lt, tbl[i].exp_lat);
         if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
         chk_io();
      end

      // Input synchroniser: a load one cycle after the change sees the old value,
      // one issued SYNC_STAGES cycles after sees the new value.
      @(negedge i_clk);
      i_io_in[63:32] = 32'hCAFE0001;
      access(1'b0, 3'b010, 32'h7804, 32'h0, rd, er, lt);
      chk("in_early", rd, 32'h0);
      i_io_in[63:32] = 32'h0;
      repeat (4) @(posedge i_clk);
      @(negedge i_clk);
      i_io_in[63:32] = 32'hCAFE0001;
      repeat (SYNC_STAGES) @(posedge i_clk);
      access(1'b0, 3'b010, 32'h7804, 32'h0, rd, er, lt);
      chk("in_sync", rd, 32'hCAFE0001);
      chk("in_sync_lat", lt, 1);
      access(1'b0, 3'b000, 32'h7807, 32'h0, rd, er, lt);
      chk("in_lb", rd, 32'hFFFFFFCA);

      // Reset mid DMEM load: no o_done, outputs cleared, DMEM kept
      @(negedge i_clk);
      i_req = 1'b1; i_wren = 1'b0; i_funct3 = 3'b010; i_addr = 32'h2004;
      @(posedge i_clk); #1;
      i_rst = 1'b1; i_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clk); #1;
         chk("rst_mid_done", {31'b0, o_done}, 32'd0);
      end
      chk("rst_mid_rdata", o_rdata, 32'd0);
      io_at_done = o_io_out;
      model_reset_out();
      chk_io();
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      chk("rst_rel_done", {31'b0, o_done}, 32'd0);
      access(1'b0, 3'b010, 32'h2004, 32'h0, rd, er, lt);
      chk("rst_keep_mem", rd, 32'hDEADBEEF);
      chk("rst_keep_lat", lt, 2);

      // Randomised accesses against the model
      for (int i = 0; i < 16; i++) begin
         wv = $urandom;
         model_acc(1'b1, 3'b010, DMEM_BASE + 16'(4*i), wv, mrd, mer, mlt);
         access(1'b1, 3'b010, {16'h0, DMEM_BASE + 16'(4*i)}, wv, rd, er, lt);
      end
      for (int i = 0; i < 2; i++) begin
         wv = $urandom;
         a = 16'h3FF8 + 16'(4*i);
         model_acc(1'b1, 3'b010, a, wv, mrd, mer, mlt);
         access(1'b1, 3'b010, {16'h0, a}, wv, rd, er, lt);
      end
      unm[0] = 16'h1FFF; unm[1] = 16'h4000; unm[2] = 16'h7020;
      unm[3] = 16'h7808; unm[4] = 16'h0000; unm[5] = 16'hFFFC;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            @(negedge i_clk);
            i_io_in = {$urandom, $urandom};
            repeat (SYNC_STAGES + 1) @(posedge i_clk);
         end
         case ($urandom_range(0, 4))
            0: a = DMEM_BASE + 16'($urandom_range(0, 63));
            1: a = 16'h3FF8 + 16'($urandom_range(0, 7));
            2: a = OUT_BASE + 16'($urandom_range(0, 4*N_OUT-1));
            3: a = IN_BASE + 16'($urandom_range(0, 4*N_IN-1));
            default: a = unm[$urandom_range(0, 5)];
         endcase
         f3 = 3'($urandom_range(0, 7));
         w  = 1'($urandom_range(0, 1));
         wv = $urandom;
         model_acc(w, f3, a, wv, mrd, mer, mlt);
         access(w, f3, {16'($urandom), a}, wv, rd, er, lt);
         chk($sformatf("rnd%0d_err a=%h f3=%0d w=%0d", i, a, f3, w), {31'b0, er}, {31'b0, mer});
         chk($sformatf("rnd%0d_lat", i), lt, mlt);
         if (!w || mer) chk($sformatf("rnd%0d_rdata a=%h f3=%0d", i, a, f3), rd, mrd);
         chk_io();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
